// File: rtl/mult_booth.sv
// -----------------------------------------------------------------------------
// mult_booth
//   Signed 32x32 radix-2 Booth multiplier, one recoding step per clock.
//   A start pulse in IDLE captures the operands. 32 iterations follow. The
//   64-bit product is then registered onto hi/lo together with a one-cycle
//   done pulse.
//
// Ports
//   clk     in   system clock, rising edge
//   reset   in   synchronous, active-high reset
//   start   in   multiply request, sampled only in IDLE
//   a       in   [31:0] multiplicand, two's complement
//   b       in   [31:0] multiplier, two's complement
//   hi      out  [31:0] upper half of signed product, registered
//   lo      out  [31:0] lower half of signed product, registered
//   busy    out  high while in RUN or DONE, registered
//   done    out  one-cycle completion pulse, registered
//
// State table
//   state  | meaning
//   IDLE   | waiting for start; hi/lo hold the last result
//   RUN    | performing the 32 Booth iterations
//   DONE   | single cycle with done=1, then back to IDLE
// -----------------------------------------------------------------------------
module mult_booth (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;

  // Datapath registers. M and P are 33 bits wide so that M = -2^31 and its
  // negation are both representable; P[32] is only a sign guard and never
  // reaches the outputs.
  logic [32:0] m_q;
  logic [32:0] p_q;
  logic [31:0] q_q;
  logic        q1_q;
  logic [5:0]  cnt_q;

  // Output registers.
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;
  logic        busy_q;

  // Next-iteration values derived from the current accumulator.
  logic [32:0] t_d;
  logic [32:0] p_d;
  logic [31:0] q_d;
  logic        q1_d;
  logic [5:0]  cnt_d;

  // One Booth step: add/subtract M according to {Q[0], q_1}, then
  // arithmetic-shift {T, Q, q_1} right by one.
  always_comb begin
    t_d = p_q;
    case ({q_q[0], q1_q})
      2'b01:   t_d = p_q + m_q;
      2'b10:   t_d = p_q - m_q;
      default: t_d = p_q;
    endcase
    p_d   = {t_d[32], t_d[32:1]};
    q_d   = {t_d[0], q_q[31:1]};
    q1_d  = q_q[0];
    cnt_d = cnt_q - 6'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      p_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            m_q     <= {a[31], a};
            p_q     <= '0;
            q_q     <= b;
            q1_q    <= 1'b0;
            cnt_q   <= 6'd32;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end

        S_RUN: begin
          p_q   <= p_d;
          q_q   <= q_d;
          q1_q  <= q1_d;
          cnt_q <= cnt_d;
          // Last iteration: publish the post-shift product on the same edge.
          if (cnt_q == 6'd1) begin
            hi_q    <= p_d[31:0];
            lo_q    <= q_d;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mult_booth.sv
module tb_mult_booth;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int checks = 0;
  int passes = 0;

  // Last result the outputs are expected to be holding.
  logic [31:0] last_hi;
  logic [31:0] last_lo;

  mult_booth dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .a    (a),
    .b    (b),
    .hi   (hi),
    .lo   (lo),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  // Reference: exact 64-bit signed product by plain arithmetic.
  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
    longint sx;
    longint sy;
    sx = $signed(x);
    sy = $signed(y);
    return 64'(sx * sy);
  endfunction

  // Present operands with start for one edge (the accept edge E0); returns at
  // the falling edge just after E0.
  task automatic launch(input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  // Count edges after E0 until done is seen (bounded), and note whether hi/lo
  // moved away from the held result before completion.
  task automatic wait_done(output int cyc, output bit stable);
    cyc    = 0;
    stable = 1'b1;
    while (cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done) break;
      if (hi !== last_hi || lo !== last_lo) stable = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (hi !== 32'h0) $display("FAIL reset_hi: got %h expected %h", hi, 32'h0); else passes++;
    checks++; if (lo !== 32'h0) $display("FAIL reset_lo: got %h expected %h", lo, 32'h0); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passes++;
    reset   = 1'b0;
    last_hi = '0;
    last_lo = '0;
  endtask

  task automatic test_basic();
    int cyc;
    bit stable;
    launch(32'd3, 32'd5);
    checks++; if (busy !== 1'b1) $display("FAIL basic_busy_after_accept: got %b expected 1", busy); else passes++;
    wait_done(cyc, stable);
    checks++; if (cyc != 32) $display("FAIL basic_latency: got %0d expected 32", cyc); else passes++;
    checks++; if (hi !== 32'h0000_0000) $display("FAIL basic_hi: got %h expected %h", hi, 32'h0); else passes++;
    checks++; if (lo !== 32'h0000_000F) $display("FAIL basic_lo: got %h expected %h", lo, 32'hF); else passes++;
    checks++; if (!stable) $display("FAIL basic_hold: got changed expected stable"); else passes++;
    last_hi = hi;
    last_lo = lo;
    @(posedge clk);
    @(negedge clk);
    checks++; if (done !== 1'b0) $display("FAIL basic_done_width: got %b expected 0", done); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy_drop: got %b expected 0", busy); else passes++;
  endtask

  task automatic test_corners();
    logic [31:0] xs [3];
    logic [31:0] ys [3];
    logic [63:0] exp_p [3];
    logic [63:0] got;
    int cyc;
    bit stable;
    xs[0] = 32'hFFFF_FFFF; ys[0] = 32'hFFFF_FFFF; exp_p[0] = 64'h0000_0000_0000_0001;
    xs[1] = 32'h8000_0000; ys[1] = 32'h8000_0000; exp_p[1] = 64'h4000_0000_0000_0000;
    xs[2] = 32'h7FFF_FFFF; ys[2] = 32'hFFFF_FFFF; exp_p[2] = 64'hFFFF_FFFF_8000_0001;
    for (int i = 0; i < 3; i++) begin
      launch(xs[i], ys[i]);
      wait_done(cyc, stable);
      got = {hi, lo};
      checks++; if (cyc != 32) $display("FAIL corner%0d_latency: got %0d expected 32", i, cyc); else passes++;
      checks++; if (got !== exp_p[i]) $display("FAIL corner%0d_product: got %h expected %h", i, got, exp_p[i]); else passes++;
      checks++; if (got !== ref_prod(xs[i], ys[i])) $display("FAIL corner%0d_model: got %h expected %h", i, got, ref_prod(xs[i], ys[i])); else passes++;
      last_hi = hi;
      last_lo = lo;
      @(posedge clk);
    end
  endtask

  task automatic test_ignored_start();
    int ndone;
    int first;
    launch(32'd7, 32'd6);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      @(negedge clk);
    end
    // Mid-RUN request with different operands must be neither taken nor queued.
    a     = 32'd100;
    b     = 32'd200;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ndone = (done === 1'b1) ? 1 : 0;
    first = (done === 1'b1) ? 11 : -1;
    for (int c = 12; c <= 75; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) first = c;
      end
    end
    checks++; if (ndone != 1) $display("FAIL ignored_done_count: got %0d expected 1", ndone); else passes++;
    checks++; if (first != 32) $display("FAIL ignored_done_edge: got %0d expected 32", first); else passes++;
    checks++; if (hi !== 32'd0) $display("FAIL ignored_hi: got %h expected %h", hi, 32'd0); else passes++;
    checks++; if (lo !== 32'd42) $display("FAIL ignored_lo: got %h expected %h", lo, 32'd42); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL ignored_idle: got %b expected 0", busy); else passes++;
    last_hi = hi;
    last_lo = lo;
  endtask

  task automatic test_back_to_back();
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] got;
    int cyc;
    bit stable;
    for (int i = 0; i < 4; i++) begin
      x = $urandom;
      y = $urandom;
      launch(x, y);
      wait_done(cyc, stable);
      got = {hi, lo};
      checks++; if (cyc != 32) $display("FAIL b2b%0d_latency: got %0d expected 32", i, cyc); else passes++;
      checks++; if (got !== ref_prod(x, y)) $display("FAIL b2b%0d_product: got %h expected %h", i, got, ref_prod(x, y)); else passes++;
      last_hi = hi;
      last_lo = lo;
      // launch() now waits only for the next falling edge, which follows the
      // edge that returns the FSM to IDLE: earliest possible new request.
      @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) $display("FAIL b2b%0d_busy_drop: got %b expected 0", i, busy); else passes++;
    end
  endtask

  task automatic test_reset_abort();
    int cyc;
    bit stable;
    bit seen;
    launch(32'd3, 32'd5);
    wait_done(cyc, stable);
    checks++; if (lo !== 32'd15) $display("FAIL abort_pre_lo: got %h expected %h", lo, 32'd15); else passes++;
    last_hi = hi;
    last_lo = lo;
    @(posedge clk);
    launch(32'd9, 32'd9);
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++; if (hi !== 32'h0) $display("FAIL abort_hi: got %h expected %h", hi, 32'h0); else passes++;
    checks++; if (lo !== 32'h0) $display("FAIL abort_lo: got %h expected %h", lo, 32'h0); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else passes++;
    last_hi = '0;
    last_lo = '0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) $display("FAIL abort_no_done: got activity expected none"); else passes++;
    launch(32'd9, 32'd9);
    wait_done(cyc, stable);
    checks++; if (cyc != 32) $display("FAIL abort_restart_latency: got %0d expected 32", cyc); else passes++;
    checks++; if ({hi, lo} !== 64'd81) $display("FAIL abort_restart_product: got %h expected %h", {hi, lo}, 64'd81); else passes++;
    last_hi = hi;
    last_lo = lo;
    @(posedge clk);
  endtask

  task automatic test_random();
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] got;
    logic [63:0] exp_v;
    int cyc;
    bit stable;
    for (int i = 0; i < 1000; i++) begin
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: x = 32'h8000_0000;
        1: y = 32'h8000_0000;
        2: x = 32'h0;
        3: y = 32'hFFFF_FFFF;
        default: ;
      endcase
      exp_v = ref_prod(x, y);
      launch(x, y);
      wait_done(cyc, stable);
      got = {hi, lo};
      checks++; if (cyc != 32) $display("FAIL rand%0d_latency: got %0d expected 32", i, cyc); else passes++;
      checks++; if (got !== exp_v) $display("FAIL rand%0d_product a=%h b=%h: got %h expected %h", i, x, y, got, exp_v); else passes++;
      checks++; if (!stable) $display("FAIL rand%0d_hold: got changed expected stable", i); else passes++;
      last_hi = hi;
      last_lo = lo;
      @(posedge clk);
      @(negedge clk);
      checks++; if (done !== 1'b0) $display("FAIL rand%0d_done_width: got %b expected 0", i, done); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_ignored_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
